// File: rtl/exe_out_ctrl.sv
// Writeback stage: on each k_fin, drains WORDS result words from the lane
// result register file into the destination buffer at base iter*WORDS.
// Reads are pipelined one word ahead of writes; destination backpressure
// freezes the write and stops further reads until it is accepted.
module exe_out_ctrl #(
    parameter int DW    = 32,
    parameter int WORDS = 64,
    parameter int ITER  = 8,
    parameter int RAW   = $clog2(WORDS),
    parameter int DAW   = $clog2(WORDS * ITER)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_init,
    input  logic           k_fin,
    output logic           rf_rd_en,
    output logic [RAW-1:0] rf_rd_addr,
    input  logic [DW-1:0]  rf_rd_data,
    output logic           dst_we,
    input  logic           dst_ready,
    output logic [DAW-1:0] dst_addr,
    output logic [DW-1:0]  dst_wdata,
    output logic           out_busy,
    output logic           out_fin,
    output logic           err
);

    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [RAW:0]   rd_idx_q, rd_idx_d;   // one extra bit: counts up to WORDS
    logic [RAW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic           pend_q, pend_d;
    logic           landed_q;             // read issued last cycle: rf_rd_data is live
    logic [DW-1:0]  hold_q;
    logic           err_q, err_d;

    logic issue;
    logic accept;
    logic last_wr;

    assign issue   = (state_q == RUN) && (rd_idx_q < (RAW+1)'(WORDS)) && (!pend_q || dst_ready);
    assign accept  = pend_q && dst_ready;
    assign last_wr = accept && (wr_idx_q == RAW'(WORDS - 1));

    // Next-state for FSM, indices, iteration counter and sticky error
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        iter_d   = iter_q;
        pend_d   = pend_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                // s_init clears iter before a same-cycle k_fin starts the drain
                if (s_init) begin
                    iter_d = '0;
                    err_d  = 1'b0;
                end
                if (k_fin) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_wr) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && (s_init || k_fin)) begin
            err_d = 1'b1;
        end

        if (issue) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end
        if (accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
        end

        // A read landing refills the holding slot even if the old word leaves
        if (issue) begin
            pend_d = 1'b1;
        end else if (accept) begin
            pend_d = 1'b0;
        end

        if (last_wr) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            iter_d   = (iter_q == IW'(ITER - 1)) ? '0 : iter_q + 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            iter_q   <= '0;
            pend_q   <= 1'b0;
            landed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            iter_q   <= iter_d;
            pend_q   <= pend_d;
            landed_q <= issue;
            err_q    <= err_d;
        end
    end

    // Holding register captures each word the cycle it arrives from the RF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (landed_q) begin
            hold_q <= rf_rd_data;
        end
    end

    // Fresh data is forwarded straight from the RF; stalled data comes from hold_q
    assign dst_wdata  = landed_q ? rf_rd_data : hold_q;
    assign dst_we     = pend_q;
    assign dst_addr   = DAW'(iter_q) * DAW'(WORDS) + DAW'(wr_idx_q);
    assign rf_rd_en   = issue;
    assign rf_rd_addr = rd_idx_q[RAW-1:0];
    assign out_busy   = (state_q == RUN);
    assign out_fin    = (state_q == FIN);
    assign err        = err_q;

endmodule

// File: tb/tb_exe_out_ctrl.sv
// Scoreboard bench for exe_out_ctrl: each accepted k_fin pushes the expected
// WORDS (addr, data) writes; a negedge monitor pops one per accepted write.
module tb_exe_out_ctrl;

    localparam int DW    = 32;
    localparam int WORDS = 64;
    localparam int ITER  = 8;
    localparam int RAW   = $clog2(WORDS);
    localparam int DAW   = $clog2(WORDS * ITER);

    logic           clk;
    logic           rst;
    logic           s_init;
    logic           k_fin;
    logic           rf_rd_en;
    logic [RAW-1:0] rf_rd_addr;
    logic [DW-1:0]  rf_rd_data;
    logic           dst_we;
    logic           dst_ready;
    logic [DAW-1:0] dst_addr;
    logic [DW-1:0]  dst_wdata;
    logic           out_busy;
    logic           out_fin;
    logic           err;

    exe_out_ctrl #(
        .DW   (DW),
        .WORDS(WORDS),
        .ITER (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_init    (s_init),
        .k_fin     (k_fin),
        .rf_rd_en  (rf_rd_en),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .dst_we    (dst_we),
        .dst_ready (dst_ready),
        .dst_addr  (dst_addr),
        .dst_wdata (dst_wdata),
        .out_busy  (out_busy),
        .out_fin   (out_fin),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]  mem [WORDS];
    logic [DAW-1:0] exp_addr_q [$];
    logic [DW-1:0]  exp_data_q [$];
    int             model_iter = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result RF: data valid only the cycle after a read, garbage otherwise
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
        else          rf_rd_data <= $urandom();
    end

    // Monitor: scoreboard pops and stall-stability checks
    logic           prev_stall = 1'b0;
    logic [DAW-1:0] prev_addr  = '0;
    logic [DW-1:0]  prev_data  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_we_held", dst_we, 1);
                chk("stall_addr_held", dst_addr, prev_addr);
                chk("stall_data_held", dst_wdata, prev_data);
            end
            if (dst_we && !dst_ready) chk("no_read_in_stall", rf_rd_en, 0);
            if (dst_we && dst_ready) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    chk("wr_addr", dst_addr, exp_addr_q.pop_front());
                    chk("wr_data", dst_wdata, exp_data_q.pop_front());
                end
            end
            prev_stall <= dst_we && !dst_ready;
            prev_addr  <= dst_addr;
            prev_data  <= dst_wdata;
        end
    end

    // Reference: a drain writes mem[n] to base*WORDS+n for every n
    task automatic push_drain();
        for (int n = 0; n < WORDS; n++) begin
            exp_addr_q.push_back(DAW'(model_iter * WORDS + n));
            exp_data_q.push_back(mem[n]);
        end
        model_iter = (model_iter + 1) % ITER;
    endtask

    task automatic fill_random();
        for (int n = 0; n < WORDS; n++) mem[n] = $urandom();
    endtask

    task automatic pulse_init();
        @(posedge clk); #1;
        s_init = 1'b1;
        model_iter = 0;
        @(posedge clk); #1;
        s_init = 1'b0;
    endtask

    // One drain. Cycle 0 is the k_fin cycle. st_lo..st_hi: dst_ready low;
    // mid: cycle of a stray pulse (k_fin, or s_init if mid_init); rst_at: reset
    // assert cycle; rnd: random backpressure; exp_fin <= 0 skips timing checks.
    task automatic run_drain(input int st_lo, input int st_hi, input int mid, input bit mid_init,
                             input int rst_at, input bit rnd, input int exp_fin,
                             input bit with_init);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        if (with_init) begin
            s_init = 1'b1;
            model_iter = 0;
        end
        k_fin = 1'b1;
        dst_ready = 1'b1;
        push_drain();
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(posedge clk); #1;
            s_init = mid_init && (cyc == mid);
            k_fin  = !mid_init && (cyc == mid);
            if (cyc == rst_at) rst = 1'b0;
            dst_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc <= st_hi);
            @(negedge clk);
            if (cyc == rst_at) begin
                chk("rst_busy", out_busy, 0);
                chk("rst_we", dst_we, 0);
                chk("rst_rd_en", rf_rd_en, 0);
                exp_addr_q.delete();
                exp_data_q.delete();
                model_iter = 0;
                @(posedge clk); #1;
                rst = 1'b1;
                done = 1'b1;
            end else begin
                if (exp_fin > 0) chk("busy", out_busy, (cyc < exp_fin) ? 1 : 0);
                if (out_fin) begin
                    done = 1'b1;
                    if (exp_fin > 0) chk("fin_cycle", cyc, exp_fin);
                    chk("queue_drained", exp_addr_q.size(), 0);
                end
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
        dst_ready = 1'b1;
        s_init = 1'b0;
        k_fin = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        s_init = 1'b0;
        k_fin = 1'b0;
        dst_ready = 1'b0;
        rf_rd_data = '0;
        #12;
        chk("reset_rd_en", rf_rd_en, 0);
        chk("reset_rd_addr", rf_rd_addr, 0);
        chk("reset_we", dst_we, 0);
        chk("reset_addr", dst_addr, 0);
        chk("reset_wdata", dst_wdata, 0);
        chk("reset_busy", out_busy, 0);
        chk("reset_fin", out_fin, 0);
        chk("reset_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic drain, then the rest of the i-loop plus a wrapping ninth drain
        for (int n = 0; n < WORDS; n++) mem[n] = DW'(32'h1000 + n);
        pulse_init();
        run_drain(-1, -1, -1, 1'b0, -1, 1'b0, 66, 1'b0);
        for (int k = 1; k <= ITER; k++) begin
            @(posedge clk);
            fill_random();
            run_drain(-1, -1, -1, 1'b0, -1, 1'b0, 66, 1'b0);
        end
        chk("err_clean", err, 0);

        // Backpressure during cycles 10..14 delays out_fin by 5
        @(posedge clk);
        fill_random();
        run_drain(10, 14, -1, 1'b0, -1, 1'b0, 71, 1'b0);

        // Stray k_fin mid-drain: flagged, dropped, drain unaffected
        fill_random();
        run_drain(-1, -1, 20, 1'b0, -1, 1'b0, 66, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_second_drain", out_busy, 0);
        end
        chk("err_after_kfin", err, 1);
        pulse_init();
        @(negedge clk);
        chk("err_cleared", err, 0);
        fill_random();
        run_drain(-1, -1, -1, 1'b0, -1, 1'b0, 66, 1'b0);

        // Stray s_init mid-drain: flagged, iteration counter untouched
        fill_random();
        run_drain(-1, -1, 33, 1'b1, -1, 1'b0, 66, 1'b0);
        @(negedge clk);
        chk("err_after_sinit", err, 1);

        // s_init and k_fin together: base back to 0, err cleared
        fill_random();
        run_drain(-1, -1, -1, 1'b0, -1, 1'b0, 66, 1'b1);
        @(negedge clk);
        chk("err_after_combined", err, 0);

        // Random backpressure
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_drain(-1, -1, -1, 1'b0, -1, 1'b1, 0, 1'b0);
        end

        // Reset mid-drain, then a fresh drain starts at address 0
        fill_random();
        run_drain(-1, -1, -1, 1'b0, 30, 1'b0, 66, 1'b0);
        @(negedge clk);
        chk("post_rst_busy", out_busy, 0);
        chk("post_rst_err", err, 0);
        fill_random();
        run_drain(-1, -1, -1, 1'b0, -1, 1'b0, 66, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_out_ctrl.md
Name: exe_out_ctrl

Overview:
- Writeback stage directly downstream of the execution controller.
- On each k_fin (one j-loop finished), drains WORDS result words from the lane result register file into the destination buffer at a per-iteration base address.
- Returns out_busy and out_fin to the execution controller, which gate the next k_init and the final s_fin.

Parameters:
- DW, 32, result word width in bits.
- WORDS, 64, words drained per k_fin.
- ITER, 8, k_fin events per s_init (i-loop length).
- RAW, $clog2(WORDS), result RF address width.
- DAW, $clog2(WORDS*ITER), destination buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- s_init  in  1  new source block accepted; clears iteration counter.
- k_fin  in  1  single-cycle pulse; results of one j-loop are ready in the result RF.
- rf_rd_en  out  1  result RF read strobe.
- rf_rd_addr  out  RAW  result RF read address.
- rf_rd_data  in  DW  read data, valid exactly 1 cycle after rf_rd_en.
- dst_we  out  1  destination write request.
- dst_ready  in  1  destination accepts the write this cycle (backpressure).
- dst_addr  out  DAW  destination write address.
- dst_wdata  out  DW  destination write data.
- out_busy  out  1  drain in progress.
- out_fin  out  1  single-cycle pulse; drain of one k_fin is complete.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async): state IDLE, iter=0, rd_idx=0, wr_idx=0, pend=0, err=0. All outputs are 0.
- States:
  - IDLE: k_fin=1 -> RUN; out_busy=1 from the next cycle.
  - RUN: read/write pipeline below.
  - FIN: one cycle; out_fin=1, out_busy=0 -> IDLE.
- Read issue in RUN: rf_rd_en=1, rf_rd_addr=rd_idx when rd_idx<WORDS and (pend=0 or dst_ready=1). rd_idx increments on issue.
- Holding register: loads rf_rd_data and sets pend the cycle after an issue. Clears when the write is accepted and no new read landed.
- Write: dst_we=pend, dst_wdata=holding register, dst_addr=iter*WORDS+wr_idx. A write is accepted on dst_we&dst_ready, which increments wr_idx. While dst_ready=0, dst_we/addr/data hold stable and no new read issues.
- Last write (wr_idx=WORDS-1 accepted):
  - Next state is FIN.
  - iter increments, wrapping from ITER-1 to 0.
  - rd_idx and wr_idx clear.
- Latency with dst_ready held 1, k_fin at cycle 0:
  - rf_rd_en cycles 1..64.
  - dst_we cycles 2..65.
  - out_fin at cycle 66; out_busy high cycles 1..65.
- s_init in IDLE: iter=0, err=0.
- s_init in RUN/FIN: ignored except err=1.
- k_fin in RUN/FIN: dropped, err=1.
- s_init and k_fin in the same IDLE cycle: iter clears first, then the drain starts with base address 0.
- Address arithmetic is unsigned; iter*WORDS+wr_idx never exceeds WORDS*ITER-1.

Test Plan:
- Basic drain: reset, s_init, k_fin with RF word n = 0x1000+n and dst_ready=1 -> 64 writes to addr 0..63 with data 0x1000..0x103F; out_fin at cycle 66; out_busy cycles 1..65.
- Full i-loop: 8 k_fin pulses, each issued 2 cycles after the previous out_fin -> write ranges 0..63, 64..127, ..., 448..511. The 9th k_fin writes at 0..63 (wrap).
- Backpressure: dst_ready low during cycles 10..14 of a drain -> dst_addr/dst_wdata frozen, no rf_rd_en in those cycles, no lost or duplicated word; out_fin delayed by exactly 5 cycles (cycle 71).
- Protocol error: k_fin pulsed at cycle 20 of a drain -> err=1, current drain unaffected, no second drain. A later s_init in IDLE clears err and sets base address to 0.
- Reset mid-drain: rst low at cycle 30 -> out_busy, dst_we, rf_rd_en drop immediately. After release, the next k_fin writes at addr 0..63.
